// File: rtl/alu_exec_if.sv
// ALU execute-unit bus: operand/strobe inputs from the control FSM,
// registered result and status back to the output stage.
interface alu_exec_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0]   Datain;
  logic               ldA;
  logic               ldB;
  logic               aCmp;
  logic               aAdd;
  logic               aSub;
  logic               aDiv;
  logic               aMul;
  logic [2*WIDTH-1:0] result;
  logic               carry;
  logic               cmp_gt;
  logic               cmp_eq;
  logic               cmp_lt;
  logic               div_zero;
  logic               op_err;
  logic               busy;
  logic               done;

  modport master (
    output Datain, ldA, ldB,
    output aCmp, aAdd, aSub, aDiv, aMul,
    input  result, carry,
    input  cmp_gt, cmp_eq, cmp_lt,
    input  div_zero, op_err, busy, done
  );

  modport slave (
    input  Datain, ldA, ldB,
    input  aCmp, aAdd, aSub, aDiv, aMul,
    output result, carry,
    output cmp_gt, cmp_eq, cmp_lt,
    output div_zero, op_err, busy, done
  );
endinterface

// File: rtl/alu_exec_unit.sv
// ALU datapath: single-cycle ADD/SUB/CMP, iterative shift-add MUL
// and restoring DIV, with registered result, flags and done pulse.
module alu_exec_unit #(
  parameter int WIDTH = 4
) (
  input logic       clk,
  input logic       reset,
  alu_exec_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE, MUL_RUN, DIV_RUN, FINISH
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [WIDTH-1:0]   r_wa, r_wb, r_rem;
  logic [2*WIDTH-1:0] r_acc, r_mcand;
  logic [CW-1:0]      r_cnt;
  logic               r_is_div, r_dz;
  logic [2*WIDTH-1:0] r_result;
  logic               r_carry;
  logic               r_gt, r_eq, r_lt;
  logic               r_dzf, r_err;
  logic               r_busy, r_done;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH:0]     w_rem_sh;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_sub;
  logic [2:0]         w_nops;
  logic               w_last;

  assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff = r_a - r_b;

  assign w_rem_sh  = {r_rem, r_wa[WIDTH-1]};
  assign w_ge      = w_rem_sh >= {1'b0, r_wb};
  // quotient bit set means the partial remainder fits in WIDTH bits
  assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_wb;

  assign w_nops = {2'b0, bus.aCmp} + {2'b0, bus.aAdd}
                + {2'b0, bus.aSub} + {2'b0, bus.aDiv}
                + {2'b0, bus.aMul};
  assign w_last = r_cnt == CW'(WIDTH - 1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_wa     <= '0;
      r_wb     <= '0;
      r_rem    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_dz     <= 1'b0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_gt     <= 1'b0;
      r_eq     <= 1'b0;
      r_lt     <= 1'b0;
      r_dzf    <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.ldA) r_a <= bus.Datain;
          if (bus.ldB) r_b <= bus.Datain;
          if (w_nops > 3'd1) begin
            r_err <= 1'b1;
          end else if (w_nops == 3'd1) begin
            r_err <= 1'b0;
            unique case (1'b1)
              bus.aAdd: begin
                r_result <= {{(WIDTH-1){1'b0}}, w_sum};
                r_carry  <= w_sum[WIDTH];
                r_gt     <= 1'b0;
                r_eq     <= 1'b0;
                r_lt     <= 1'b0;
                r_dzf    <= 1'b0;
                r_done   <= 1'b1;
              end
              bus.aSub: begin
                r_result <= {{WIDTH{1'b0}}, w_diff};
                r_carry  <= r_a < r_b;
                r_gt     <= 1'b0;
                r_eq     <= 1'b0;
                r_lt     <= 1'b0;
                r_dzf    <= 1'b0;
                r_done   <= 1'b1;
              end
              bus.aCmp: begin
                r_result <= '0;
                r_carry  <= 1'b0;
                r_gt     <= r_a > r_b;
                r_eq     <= r_a == r_b;
                r_lt     <= r_a < r_b;
                r_dzf    <= 1'b0;
                r_done   <= 1'b1;
              end
              bus.aMul: begin
                r_mcand  <= {{WIDTH{1'b0}}, r_a};
                r_wa     <= r_b;
                r_acc    <= '0;
                r_cnt    <= '0;
                r_is_div <= 1'b0;
                r_busy   <= 1'b1;
                r_state  <= MUL_RUN;
              end
              bus.aDiv: begin
                r_is_div <= 1'b1;
                r_wa     <= r_a;
                r_wb     <= r_b;
                r_rem    <= '0;
                r_cnt    <= '0;
                if (r_b == '0) begin
                  r_dz    <= 1'b1;
                  r_state <= FINISH;
                end else begin
                  r_dz    <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= DIV_RUN;
                end
              end
              default: ;
            endcase
          end
        end
        MUL_RUN: begin
          if (r_wa[0]) r_acc <= r_acc + r_mcand;
          r_mcand <= r_mcand << 1;
          r_wa    <= r_wa >> 1;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_busy  <= 1'b0;
            r_state <= FINISH;
          end
        end
        DIV_RUN: begin
          r_rem <= w_ge ? w_rem_sub
                        : w_rem_sh[WIDTH-1:0];
          r_wa  <= {r_wa[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_busy  <= 1'b0;
            r_state <= FINISH;
          end
        end
        FINISH: begin
          r_carry <= 1'b0;
          r_gt    <= 1'b0;
          r_eq    <= 1'b0;
          r_lt    <= 1'b0;
          r_done  <= 1'b1;
          r_state <= IDLE;
          if (r_is_div) begin
            r_dzf    <= r_dz;
            r_result <= r_dz ? '1 : {r_rem, r_wa};
          end else begin
            r_dzf    <= 1'b0;
            r_result <= r_acc;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.result   = r_result;
  assign bus.carry    = r_carry;
  assign bus.cmp_gt   = r_gt;
  assign bus.cmp_eq   = r_eq;
  assign bus.cmp_lt   = r_lt;
  assign bus.div_zero = r_dzf;
  assign bus.op_err   = r_err;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed ops push expectations,
// a negedge monitor pops and checks on every done pulse.
module tb_alu_exec_unit;
  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;

  alu_exec_if #(.WIDTH(4)) bus ();

  alu_exec_unit #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string      nm;
    int         cyc;
    logic [7:0] res;
    logic [4:0] fl;
  } exp_t;

  exp_t q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // flags packed as {carry, gt, eq, lt, div_zero}
  always @(negedge clk) begin
    if (reset && bus.done) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done cyc=%0d result=%h",
                 cyc, bus.result);
      end else begin
        exp_t e;
        logic [4:0] f;
        e = q.pop_front();
        f = {bus.carry, bus.cmp_gt, bus.cmp_eq,
             bus.cmp_lt, bus.div_zero};
        if (bus.result !== e.res || f !== e.fl
            || cyc != e.cyc) begin
          errors++;
          $display("FAIL %s: got res=%h fl=%b cyc=%0d exp res=%h fl=%b cyc=%0d",
                   e.nm, bus.result, f, cyc, e.res, e.fl, e.cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h exp %h", nm, act, exp);
    end
  endtask

  // st = {aCmp, aAdd, aSub, aDiv, aMul}; lat 0 means no done expected
  task automatic op(input string nm,
                    input logic la, input logic lb,
                    input logic [3:0] d,
                    input logic [4:0] st,
                    input int lat,
                    input logic [7:0] res,
                    input logic [4:0] fl);
    exp_t e;
    if (lat > 0) begin
      e.nm  = nm;
      e.cyc = cyc + lat;
      e.res = res;
      e.fl  = fl;
      q.push_back(e);
    end
    bus.ldA    = la;
    bus.ldB    = lb;
    bus.Datain = d;
    {bus.aCmp, bus.aAdd, bus.aSub, bus.aDiv, bus.aMul} = st;
    step();
    bus.ldA = 1'b0;
    bus.ldB = 1'b0;
    {bus.aCmp, bus.aAdd, bus.aSub, bus.aDiv, bus.aMul} = '0;
  endtask

  task automatic ld(input logic [3:0] a, input logic [3:0] b);
    op("ldA", 1'b1, 1'b0, a, 5'b0, 0, 8'h0, 5'b0);
    op("ldB", 1'b0, 1'b1, b, 5'b0, 0, 8'h0, 5'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && q.size() != 0; i++) step();
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d done pulses missing", q.size());
      q.delete();
    end
    step();
  endtask

  localparam logic [4:0] CMP = 5'b10000;
  localparam logic [4:0] ADD = 5'b01000;
  localparam logic [4:0] SUB = 5'b00100;
  localparam logic [4:0] DIV = 5'b00010;
  localparam logic [4:0] MUL = 5'b00001;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bus.Datain = '0;
    bus.ldA = 1'b0;
    bus.ldB = 1'b0;
    {bus.aCmp, bus.aAdd, bus.aSub, bus.aDiv, bus.aMul} = '0;
    step();
    step();
    reset = 1'b1;
    chk("rst_result", 32'(bus.result), 32'h0);
    chk("rst_flags", 32'({bus.carry, bus.cmp_gt, bus.cmp_eq,
        bus.cmp_lt, bus.div_zero, bus.op_err,
        bus.busy, bus.done}), 32'h0);

    // reset aborts an in-flight MUL
    ld(4'd15, 4'd15);
    op("mul_abort", 0, 0, 4'd0, MUL, 0, 8'h0, 5'b0);
    chk("abort_busy_pre", 32'(bus.busy), 32'h1);
    step();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    chk("abort_result", 32'(bus.result), 32'h0);
    chk("abort_busy", 32'(bus.busy), 32'h0);
    repeat (8) step();
    ld(4'd1, 4'd1);
    op("add_post_rst", 0, 0, 4'd0, ADD, 1, 8'h02, 5'b00000);
    drain();

    ld(4'd9, 4'd5);
    op("add_9_5", 0, 0, 4'd0, ADD, 1, 8'h0E, 5'b00000);
    drain();
    ld(4'd12, 4'd7);
    op("add_12_7", 0, 0, 4'd0, ADD, 1, 8'h13, 5'b10000);
    drain();

    ld(4'd3, 4'd5);
    op("sub_3_5", 0, 0, 4'd0, SUB, 1, 8'h0E, 5'b10000);
    drain();
    op("cmp_lt", 0, 0, 4'd0, CMP, 1, 8'h00, 5'b00010);
    drain();
    op("ldA5", 1, 0, 4'd5, 5'b0, 0, 8'h0, 5'b0);
    op("cmp_eq", 0, 0, 4'd0, CMP, 1, 8'h00, 5'b00100);
    drain();

    // MUL with ignored strobes/loads while busy
    ld(4'd15, 4'd15);
    op("mul_15_15", 0, 0, 4'd0, MUL, 6, 8'hE1, 5'b00000);
    chk("mul_busy1", 32'(bus.busy), 32'h1);
    op("ign_add", 1, 0, 4'd2, ADD, 0, 8'h0, 5'b0);
    chk("mul_busy2", 32'(bus.busy), 32'h1);
    step();
    chk("mul_busy3", 32'(bus.busy), 32'h1);
    step();
    chk("mul_busy4", 32'(bus.busy), 32'h1);
    step();
    chk("mul_busy_end", 32'(bus.busy), 32'h0);
    drain();
    op("add_a_kept", 0, 0, 4'd0, ADD, 1, 8'h1E, 5'b10000);
    drain();

    ld(4'd13, 4'd4);
    op("div_13_4", 0, 0, 4'd0, DIV, 6, 8'h13, 5'b00000);
    drain();
    op("ldB0", 0, 1, 4'd0, 5'b0, 0, 8'h0, 5'b0);
    op("div_zero", 0, 0, 4'd0, DIV, 2, 8'hFF, 5'b00001);
    chk("dz_busy1", 32'(bus.busy), 32'h0);
    step();
    chk("dz_busy2", 32'(bus.busy), 32'h0);
    drain();

    // illegal strobe pair: error flag only, no done
    op("add_sub", 0, 0, 4'd0, ADD | SUB, 0, 8'h0, 5'b0);
    chk("op_err_set", 32'(bus.op_err), 32'h1);
    chk("err_result", 32'(bus.result), 32'hFF);
    step();
    chk("err_no_done", 32'(bus.done), 32'h0);
    op("cmp_gt", 0, 0, 4'd0, CMP, 1, 8'h00, 5'b01000);
    chk("op_err_clr", 32'(bus.op_err), 32'h0);
    drain();

    // same-cycle load uses old A
    ld(4'd1, 4'd2);
    op("add_old_a", 1, 0, 4'd7, ADD, 1, 8'h03, 5'b00000);
    drain();
    op("add_new_a", 0, 0, 4'd0, ADD, 1, 8'h09, 5'b00000);
    drain();

    repeat (4) step();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
